iter_mul_div: RTL
=================

# iter_mul_div

Parametrised iterative multiply/divide unit serving the EX stage. Performs signed or unsigned multiply, multiply-accumulate/subtract and divide on `WIDTH`-bit operands using one radix-2 step per clock. Returns a `2*WIDTH` {hi,lo} result through a start/ready handshake. EX holds the pipeline stalled while `busy_o` is high, and can annul an operation that has already started.

## Interface

- `WIDTH`, default 32. Operand width; must be ≥ 4. Result width is `2*WIDTH`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_i` in 1: request; sampled only in IDLE.
- `annul_i` in 1: abort the current or requested operation.
- `op_i` in 3: operation select.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU.
  - 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- `op1_i` in WIDTH: multiplicand / dividend.
- `op2_i` in WIDTH: multiplier / divisor.
- `acc_i` in 2*WIDTH: {hi,lo} accumulator for MADD/MSUB.
- `result_o` out 2*WIDTH: {hi,lo}.
  - Multiply: full product or accumulated value.
  - Divide: {remainder, quotient}.
- `ready_o` out 1: one-cycle pulse; `result_o` is valid in that cycle.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `div_zero_o` out 1: high with `ready_o` when a divide had divisor 0.

## Operation

- **FSM states:** IDLE, CALC, DONE.
- **IDLE:**
  - `start_i`=1 and `annul_i`=0: register `op_i`, `acc_i` and the operand magnitudes (two's-complement absolute value when the op is signed). Record the result signs.
  - Then go to CALC, with the step counter loaded to `WIDTH`-1.
  - DIV/DIVU with `op2_i`=0: go directly to DONE instead.
- **CALC:** one step per cycle.
  - Multiply: shift-add; test one multiplier bit and conditionally add the multiplicand into a `2*WIDTH` partial product.
  - Divide: restoring; shift in one dividend bit, trial-subtract the divisor, set one quotient bit.
  - When the counter is 0, go to DONE; otherwise decrement.
- **Transition into DONE:** `result_o` is registered on this edge.
  - Signed multiply: negate the product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ. The remainder takes the dividend's sign.
  - MADD/MADDU: `acc` + product. MSUB/MSUBU: `acc` − product. Both are modulo 2^(2*WIDTH).
  - Signed divide of the most-negative value by −1: quotient = most-negative value (wraps), remainder 0, no flag.
  - Divide by zero: `result_o` = {`op1_i`, all-ones}, `div_zero_o`=1.
- **DONE:** `ready_o`=1 for exactly this cycle. Always go to IDLE on the next edge.
- **Outputs between operations:** `result_o` holds its value until the next entry into DONE. `div_zero_o` is cleared on the edge leaving DONE.
- **start_i while not in IDLE:** ignored. There is no queueing.
- **annul_i:** high in any state forces IDLE on the next edge.
  - No `ready_o` pulse; `result_o` is unchanged.
  - If `annul_i` and `start_i` are both high in IDLE, the start is dropped.
  - If annulled in DONE, the `ready_o` pulse still appears in that cycle.
- **Operand stability:** `op1_i`, `op2_i`, `acc_i` and `op_i` are ignored after the start edge.

## Timing

- **Reset values:**
  - `result_o`=0, `ready_o`=0, `busy_o`=0, `div_zero_o`=0.
  - State = IDLE, counter = 0.
- **Asynchronous reset mid-operation:** returns immediately to the reset values. No `ready_o` pulse follows.
- **Latency:** with `start_i` sampled at the end of cycle 0:
  - CALC occupies cycles 1..`WIDTH`.
  - DONE is cycle `WIDTH`+1, with `ready_o`=1 and `busy_o`=1.
  - IDLE is cycle `WIDTH`+2, where a new start is accepted.
  - For `WIDTH`=32, `ready_o` is high in cycle 33.
- **Divide by zero:** DONE is cycle 1; the next start is accepted in cycle 2.
- **Throughput:** one operation per `WIDTH`+2 cycles.
- **busy_o:** rises in cycle 1, registered from the start edge.
  - EX must raise its stall request combinationally from `start_i` in cycle 0.
- **Registered outputs:** `result_o`, `ready_o` and `div_zero_o` are all registered, with no combinational path from the inputs.

## Test plan

- **MULT, `WIDTH`=32:** op1=0xFFFFFFFD (−3), op2=7 -> `ready_o` in cycle 33 only; `result_o`=0xFFFFFFFF_FFFFFFEB; `busy_o` high in cycles 1..33.
- **DIV −7/2 and DIVU 0xFFFFFFF9/2, back-to-back** (second start in cycle 34):
  - First result: {0xFFFFFFFF, 0xFFFFFFFD}.
  - Second result: {0x00000001, 0x7FFFFFFC}.
- **DIVU 100/0** -> `ready_o` and `div_zero_o` in cycle 1; `result_o`={0x00000064, 0xFFFFFFFF}; `div_zero_o`=0 in cycle 2.
- **MSUBU:** acc=0x00000001_00000000, 3×2 -> 0x00000000_FFFFFFFA. **MADD:** acc=0, (−1)×(−1) -> 0x1.
- **Annul and reset:**
  - Start MULT; `annul_i` in cycle 10 -> no `ready_o`; `busy_o`=0 from cycle 11; new start in cycle 11 completes in cycle 44.
  - Start DIV; assert `rst` in cycle 5 -> all outputs 0 immediately, no later `ready_o`.
  - Start issued in cycle 5 while busy -> ignored.
- **`WIDTH`=8, signed DIV 0x80/0xFF** -> `result_o`=0x0080, `ready_o` in cycle 9. MULTU 0xFF×0xFF -> 0xFE01.

Source files
------------

// File: rtl/iter_mul_div.sv
`default_nettype none
// ============================================================================
// Module      : iter_mul_div
// Description : Iterative radix-2 multiply / divide unit for the EX stage.
//               Signed/unsigned multiply, multiply-accumulate/subtract and
//               restoring divide, one bit per clock, {hi,lo} result.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   start_i     in   operation request, sampled only in IDLE
//   annul_i     in   abort current/requested operation
//   op_i        in   [2:0] 000 MULT 001 MULTU 010 DIV 011 DIVU
//                         100 MADD 101 MADDU 110 MSUB 111 MSUBU
//   op1_i       in   [WIDTH-1:0] multiplicand / dividend
//   op2_i       in   [WIDTH-1:0] multiplier / divisor
//   acc_i       in   [2*WIDTH-1:0] {hi,lo} accumulator for MADD/MSUB
//   result_o    out  [2*WIDTH-1:0] product/accumulation or {rem,quot}
//   ready_o     out  one-cycle pulse, result_o valid
//   busy_o      out  high whenever not IDLE
//   div_zero_o  out  high with ready_o when divisor was zero
// ============================================================================
module iter_mul_div #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic [2:0]           op_i,
  input  logic [WIDTH-1:0]     op1_i,
  input  logic [WIDTH-1:0]     op2_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 div_zero_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_CNT_INIT = CW'(WIDTH - 1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_CALC = 2'd1;
  localparam logic [1:0] c_S_DONE = 2'd2;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_a;      // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   r_hi;     // partial product high / partial remainder
  logic [WIDTH-1:0]   r_lo;     // multiplier bits / dividend bits + quotient
  logic               r_neg_q;  // negate product or quotient at the end
  logic               r_neg_r;  // negate remainder at the end
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_div0;

  // --------------------------------------------------------------------------
  // Request decode (IDLE only)
  // --------------------------------------------------------------------------
  logic             w_in_signed;
  logic             w_in_div;
  logic             w_op1_neg;
  logic             w_op2_neg;
  logic [WIDTH-1:0] w_op1_mag;
  logic [WIDTH-1:0] w_op2_mag;
  logic             w_div_zero_req;

  assign w_in_signed    = ~op_i[0];
  assign w_in_div       = (op_i[2:1] == 2'b01);
  assign w_op1_neg      = w_in_signed & op1_i[WIDTH-1];
  assign w_op2_neg      = w_in_signed & op2_i[WIDTH-1];
  assign w_op1_mag      = w_op1_neg ? (~op1_i + 1'b1) : op1_i;
  assign w_op2_mag      = w_op2_neg ? (~op2_i + 1'b1) : op2_i;
  assign w_div_zero_req = w_in_div & (op2_i == '0);

  // --------------------------------------------------------------------------
  // Registered op decode
  // --------------------------------------------------------------------------
  logic w_is_div;
  logic w_is_acc;
  logic w_is_sub;

  assign w_is_div = (r_op[2:1] == 2'b01);
  assign w_is_acc = r_op[2];
  assign w_is_sub = r_op[2] & r_op[1];

  // --------------------------------------------------------------------------
  // Multiply step: add the multiplicand into the high half when the current
  // multiplier bit is set, then shift {carry,hi,lo} right by one. After WIDTH
  // steps the multiplier has been shifted out and {hi,lo} is the product.
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;

  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

  // --------------------------------------------------------------------------
  // Restoring divide step: shift the next dividend bit into the remainder,
  // trial-subtract, and shift the quotient bit into the bottom of r_lo.
  // The remainder is always below the divisor, so the subtraction result
  // fits in WIDTH bits.
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_a});
  assign w_div_hi    = w_div_ge ? (w_div_shift[WIDTH-1:0] - r_a) : w_div_shift[WIDTH-1:0];
  assign w_div_lo    = {r_lo[WIDTH-2:0], w_div_ge};

  logic [WIDTH-1:0] w_hi_nx;
  logic [WIDTH-1:0] w_lo_nx;

  assign w_hi_nx = w_is_div ? w_div_hi : w_mul_hi;
  assign w_lo_nx = w_is_div ? w_div_lo : w_mul_lo;

  // --------------------------------------------------------------------------
  // Final result from the last step's values. Sign fix-up for the most
  // negative dividend over -1 wraps naturally: the quotient magnitude is
  // 2^(WIDTH-1) and negating it gives back the same bit pattern.
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_prod_mag;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mac;
  logic [2*WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_final;

  assign w_prod_mag = {w_hi_nx, w_lo_nx};
  assign w_prod     = r_neg_q ? (~w_prod_mag + 1'b1) : w_prod_mag;
  assign w_mac      = w_is_sub ? (r_acc - w_prod) : (r_acc + w_prod);
  assign w_mul_res  = w_is_acc ? w_mac : w_prod;
  assign w_quot     = r_neg_q ? (~w_lo_nx + 1'b1) : w_lo_nx;
  assign w_rem      = r_neg_r ? (~w_hi_nx + 1'b1) : w_hi_nx;
  assign w_final    = w_is_div ? {w_rem, w_quot} : w_mul_res;

  // --------------------------------------------------------------------------
  // Control FSM and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          if (start_i && !annul_i) begin
            r_op    <= op_i;
            r_acc   <= acc_i;
            r_hi    <= '0;
            r_a     <= w_in_div ? w_op2_mag : w_op1_mag;
            r_lo    <= w_in_div ? w_op1_mag : w_op2_mag;
            r_neg_q <= w_op1_neg ^ w_op2_neg;
            r_neg_r <= w_op1_neg;
            r_cnt   <= c_CNT_INIT;
            if (w_div_zero_req) begin
              // Divide by zero skips the iteration entirely.
              r_state  <= c_S_DONE;
              r_result <= {op1_i, {WIDTH{1'b1}}};
              r_ready  <= 1'b1;
              r_div0   <= 1'b1;
            end else begin
              r_state <= c_S_CALC;
            end
          end
        end
        c_S_CALC: begin
          if (annul_i) begin
            r_state <= c_S_IDLE;
          end else begin
            r_hi <= w_hi_nx;
            r_lo <= w_lo_nx;
            if (r_cnt == '0) begin
              r_state  <= c_S_DONE;
              r_result <= w_final;
              r_ready  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        c_S_DONE: begin
          r_state <= c_S_IDLE;
          r_div0  <= 1'b0;
        end
        default: begin
          r_state <= c_S_IDLE;
        end
      endcase
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign busy_o     = (r_state != c_S_IDLE);
  assign div_zero_o = r_div0;

endmodule
`default_nettype wire
